instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Boot-time loader that sits directly upstream of the single-cycle RISC-V core's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes those words into sequential instruction-memory locations and verifies a trailing XOR checksum.
- Holds the core in reset until a load completes cleanly, then releases it.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity is 2**ADDR_W words.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
load_en  input  1  loader enable; high = accept a load session.
byte_in  input  8  stream byte.
byte_valid  input  1  byte_in is valid this cycle.
byte_ready  output  1  loader can accept a byte this cycle.
imem_we  output  1  one-cycle instruction-memory write strobe.
imem_addr  output  ADDR_W  word address for the write.
imem_wdata  output  32  assembled instruction word.
cpu_rst  output  1  active-high hold-reset for the core.
load_done  output  1  load completed and checksum matched (sticky).
load_err  output  1  length overflow or checksum mismatch.
word_count  output  16  declared word count of the current or last session.

Behaviour:
- Async reset (rst=1): state=IDLE; byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, load_err=0, word_count=0; cpu_rst=1.
- Transfer rule: a byte is accepted only on a rising edge with byte_valid && byte_ready. byte_valid with byte_ready=0 is ignored and nothing is queued.
- byte_ready = load_en in states LEN_LO, LEN_HI, DATA, CHK; otherwise 0.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes (LSB first per word), then 1 checksum byte.
  - Checksum = XOR of every preceding byte in the frame, including the length bytes.
- Running XOR register, byte-lane counter (2 bits) and word counter reset at session start.

State machine:
- IDLE: load_en=1 -> LEN_LO next cycle; clear xor, lane, word counter, load_err.
- LEN_LO: on accept, latch word_count[7:0] -> LEN_HI.
- LEN_HI: on accept, latch word_count[15:8].
  - N > 2**ADDR_W -> ERR.
  - N = 0 -> CHK.
  - Otherwise -> DATA.
- DATA: each accepted byte fills lane (0..3) of the assembly register.
  - On lane-3 accept: the next cycle drives imem_we=1 for exactly one cycle, with imem_wdata = assembled word and imem_addr = word index (first word at 0).
  - Word index increments after the write.
  - After word N-1 is accepted -> CHK.
- CHK: on accept, compare with running XOR.
  - Equal -> RUN.
  - Unequal -> ERR.
- RUN: cpu_rst=0, load_done=1. Sticky until rst; load_en is ignored.
- ERR: load_err=1, cpu_rst=1. load_en=0 -> IDLE, where load_err clears on the next session start.
- load_en falls in LEN_LO..CHK: abort to IDLE next cycle.
  - Words already written remain in memory; cpu_rst stays 1.
  - load_done/load_err are unchanged (0).
  - The lane counter clears, so a partial word is discarded with no write.
- Last data write and the CHK transition: the final imem_we pulse occurs in the cycle after the last data byte, which may coincide with the checksum accept. Both must take effect.
- cpu_rst deasserts the cycle after RUN is entered and never before the final write.
- Sustained throughput: one byte per cycle with byte_valid held high, no bubbles.
- Reset mid-session: immediate return to reset values; the session is lost.

Test Plan:
- Nominal load: load_en=1; stream 02 00 E3 01 10 00 13 00 00 00 E3 at 1 byte/cycle.
  - Expect imem_we at addr 0 with data 0x001001E3, then addr 1 with data 0x00000013.
  - Expect word_count=2, load_done=1, cpu_rst=0, load_err=0.
- Bad checksum: same frame with last byte 0xE2.
  - Expect two writes, then load_err=1, cpu_rst=1, load_done=0.
  - load_en=0 -> IDLE; a new good frame then completes.
- Length overflow (ADDR_W=8): send 01 01 (N=257).
  - Expect ERR immediately after LEN_HI, no imem_we, byte_ready=0.
- Zero-length frame: send 00 00 00.
  - Expect no writes; load_done=1, cpu_rst=0.
- Backpressure/gaps: nominal frame with byte_valid toggled randomly and load_en low for 3 cycles mid-word 1.
  - Expect abort with only word 0 written.
  - A restarted full frame writes both words correctly.
- Async reset asserted between lanes 2 and 3 of word 0.
  - Expect immediate IDLE, cpu_rst=1, and no write pulse.

Source files
------------

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - boot loader: byte stream to instruction memory with XOR checksum
module instr_mem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_RUN, S_ERR
  } state_t;

  // Largest frame the memory can hold; one more word than the address range would wrap.
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  state_t              state_q, state_d;
  logic [7:0]          xor_q, xor_d;
  logic [1:0]          lane_q, lane_d;
  logic [15:0]         word_idx_q, word_idx_d;
  logic [23:0]         asm_q, asm_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic [15:0]         word_count_q, word_count_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;
  logic                cpu_rst_q, cpu_rst_d;

  logic                active;
  logic                accept;
  logic [15:0]         len_full;

  assign active     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CHK);
  assign byte_ready = load_en && active;
  assign accept     = byte_ready && byte_valid;
  assign len_full   = {byte_in, word_count_q[7:0]};

  // State and datapath registers; reset holds the core and clears all status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      xor_q        <= '0;
      lane_q       <= '0;
      word_idx_q   <= '0;
      asm_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      word_count_q <= '0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      cpu_rst_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      xor_q        <= xor_d;
      lane_q       <= lane_d;
      word_idx_q   <= word_idx_d;
      asm_q        <= asm_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      word_count_q <= word_count_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      cpu_rst_q    <= cpu_rst_d;
    end
  end

  // Next-state: frame parsing, abort on load_en drop, sticky RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (load_en) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (!load_en)    state_d = S_IDLE;
        else if (accept) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (!load_en) state_d = S_IDLE;
        else if (accept) begin
          if ({1'b0, len_full} > MAX_WORDS) state_d = S_ERR;
          else if (len_full == 16'd0)       state_d = S_CHK;
          else                              state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!load_en) state_d = S_IDLE;
        else if (accept && (lane_q == 2'd3) && ((word_idx_q + 16'd1) == word_count_q))
          state_d = S_CHK;
      end
      S_CHK: begin
        if (!load_en)    state_d = S_IDLE;
        else if (accept) state_d = (byte_in == xor_q) ? S_RUN : S_ERR;
      end
      S_RUN:   state_d = S_RUN;
      S_ERR:   if (!load_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and outputs: checksum, word assembly, one-cycle write strobe, status flags.
  always_comb begin
    xor_d        = xor_q;
    lane_d       = lane_q;
    word_idx_d   = word_idx_q;
    asm_d        = asm_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    word_count_d = word_count_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    cpu_rst_d    = (state_q != S_RUN);
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          xor_d      = '0;
          lane_d     = '0;
          word_idx_d = '0;
          load_err_d = 1'b0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          word_count_d[7:0] = byte_in;
          xor_d             = xor_q ^ byte_in;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          word_count_d[15:8] = byte_in;
          xor_d              = xor_q ^ byte_in;
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d  = xor_q ^ byte_in;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: asm_d[7:0]   = byte_in;
            2'd1: asm_d[15:8]  = byte_in;
            2'd2: asm_d[23:16] = byte_in;
            default: begin
              imem_we_d    = 1'b1;
              imem_wdata_d = {byte_in, asm_q};
              imem_addr_d  = word_idx_q[ADDR_W-1:0];
              word_idx_d   = word_idx_q + 16'd1;
            end
          endcase
        end
      end
      default: ;
    endcase
    // An abort discards any partially assembled word.
    if (active && !load_en) lane_d = '0;
    if (state_d == S_ERR)   load_err_d  = 1'b1;
    if (state_d == S_RUN)   load_done_d = 1'b1;
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;
  logic [15:0] word_count;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  instr_mem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
    .load_done(load_done), .load_err(load_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Record every write strobe.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic do_reset();
    rst = 1'b1; load_en = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wr_addr.delete(); wr_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in = b; byte_valid = 1'b1;
    @(negedge clk);
    while (byte_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (byte_ready !== 1'b1) begin fails++; $display("FAIL send_byte_timeout byte=%02h ready=%b exp=1", b, byte_ready); end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) begin byte_valid = 1'b0; @(posedge clk); #1; end
    send_byte(b);
  endtask

  task automatic send_frame(input logic [7:0] last, input bit gaps);
    logic [7:0] f[11] = '{8'h02, 8'h00, 8'hE3, 8'h01, 8'h10, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hE3};
    f[10] = last;
    for (int i = 0; i < 11; i++) begin
      if (gaps) send_gap(f[i]); else send_byte(f[i]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", byte_ready); end
    checks++; if (imem_we !== 1'b0) begin fails++; $display("FAIL reset_we got=%b exp=0", imem_we); end
    checks++; if (imem_addr !== 8'h00) begin fails++; $display("FAIL reset_addr got=%h exp=00", imem_addr); end
    checks++; if (imem_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata got=%h exp=0", imem_wdata); end
    checks++; if (cpu_rst !== 1'b1) begin fails++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
    checks++; if (load_done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", load_done); end
    checks++; if (load_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", load_err); end
    checks++; if (word_count !== 16'h0) begin fails++; $display("FAIL reset_wc got=%h exp=0", word_count); end
  endtask

  task automatic test_nominal();
    do_reset();
    load_en = 1'b1;
    send_frame(8'hE3, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (wr_addr.size() != 2) begin fails++; $display("FAIL nom_nwrites got=%0d exp=2", wr_addr.size()); end
    checks++; if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h001001E3) begin fails++; $display("FAIL nom_w0 got=%h:%h exp=00:001001e3", wr_addr[0], wr_data[0]); end
    checks++; if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h00000013) begin fails++; $display("FAIL nom_w1 got=%h:%h exp=01:00000013", wr_addr[1], wr_data[1]); end
    checks++; if (word_count !== 16'd2) begin fails++; $display("FAIL nom_wc got=%0d exp=2", word_count); end
    checks++; if (load_done !== 1'b1 || cpu_rst !== 1'b0 || load_err !== 1'b0) begin fails++; $display("FAIL nom_status got done=%b rst=%b err=%b exp 1 0 0", load_done, cpu_rst, load_err); end
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (load_done !== 1'b1 || cpu_rst !== 1'b0 || byte_ready !== 1'b0) begin fails++; $display("FAIL nom_sticky got done=%b rst=%b rdy=%b exp 1 0 0", load_done, cpu_rst, byte_ready); end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    load_en = 1'b1;
    send_frame(8'hE2, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (wr_addr.size() != 2) begin fails++; $display("FAIL bad_nwrites got=%0d exp=2", wr_addr.size()); end
    checks++; if (load_err !== 1'b1 || cpu_rst !== 1'b1 || load_done !== 1'b0) begin fails++; $display("FAIL bad_status got err=%b rst=%b done=%b exp 1 1 0", load_err, cpu_rst, load_done); end
    checks++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL bad_ready got=%b exp=0", byte_ready); end
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    #1 load_en = 1'b1;
    wr_addr.delete(); wr_data.delete();
    send_frame(8'hE3, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (load_done !== 1'b1 || load_err !== 1'b0 || cpu_rst !== 1'b0) begin fails++; $display("FAIL bad_retry got done=%b err=%b rst=%b exp 1 0 0", load_done, load_err, cpu_rst); end
    checks++; if (wr_data.size() != 2 || wr_data[1] !== 32'h00000013) begin fails++; $display("FAIL bad_retry_writes got n=%0d d1=%h exp 2 00000013", wr_data.size(), wr_data[1]); end
  endtask

  task automatic test_overflow();
    do_reset();
    load_en = 1'b1;
    send_byte(8'h01); send_byte(8'h01);
    @(negedge clk);
    checks++; if (load_err !== 1'b1 || byte_ready !== 1'b0) begin fails++; $display("FAIL ovf_status got err=%b rdy=%b exp 1 0", load_err, byte_ready); end
    checks++; if (wr_addr.size() != 0 || cpu_rst !== 1'b1) begin fails++; $display("FAIL ovf_writes got n=%0d rst=%b exp 0 1", wr_addr.size(), cpu_rst); end
    checks++; if (word_count !== 16'h0101) begin fails++; $display("FAIL ovf_wc got=%h exp=0101", word_count); end
    // Exactly full memory: 256 words, word i = i; checksum 00^01^(xor of 0..255) = 01.
    do_reset();
    load_en = 1'b1;
    send_byte(8'h00); send_byte(8'h01);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i)); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    end
    send_byte(8'h01);
    repeat (3) @(negedge clk);
    checks++; if (wr_addr.size() != 256) begin fails++; $display("FAIL full_nwrites got=%0d exp=256", wr_addr.size()); end
    checks++; if (wr_addr[255] !== 8'hFF || wr_data[255] !== 32'h000000FF) begin fails++; $display("FAIL full_last got=%h:%h exp=ff:000000ff", wr_addr[255], wr_data[255]); end
    checks++; if (load_done !== 1'b1 || load_err !== 1'b0) begin fails++; $display("FAIL full_status got done=%b err=%b exp 1 0", load_done, load_err); end
  endtask

  task automatic test_zero_len();
    do_reset();
    load_en = 1'b1;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    repeat (3) @(negedge clk);
    checks++; if (wr_addr.size() != 0) begin fails++; $display("FAIL zero_nwrites got=%0d exp=0", wr_addr.size()); end
    checks++; if (load_done !== 1'b1 || cpu_rst !== 1'b0 || word_count !== 16'd0) begin fails++; $display("FAIL zero_status got done=%b rst=%b wc=%0d exp 1 0 0", load_done, cpu_rst, word_count); end
  endtask

  task automatic test_gaps();
    logic [7:0] part[8] = '{8'h02, 8'h00, 8'hE3, 8'h01, 8'h10, 8'h00, 8'h13, 8'h00};
    do_reset();
    load_en = 1'b1;
    for (int i = 0; i < 8; i++) send_gap(part[i]);
    load_en = 1'b0; byte_valid = 1'b1; byte_in = 8'hAA;
    repeat (3) @(posedge clk);
    #1 byte_valid = 1'b0;
    @(negedge clk);
    checks++; if (wr_addr.size() != 1 || wr_data[0] !== 32'h001001E3) begin fails++; $display("FAIL gap_abort got n=%0d d0=%h exp 1 001001e3", wr_addr.size(), wr_data[0]); end
    checks++; if (load_done !== 1'b0 || load_err !== 1'b0 || cpu_rst !== 1'b1) begin fails++; $display("FAIL gap_abort_status got done=%b err=%b rst=%b exp 0 0 1", load_done, load_err, cpu_rst); end
    #1 load_en = 1'b1;
    send_frame(8'hE3, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (wr_addr.size() != 3 || wr_addr[1] !== 8'd0 || wr_data[1] !== 32'h001001E3) begin fails++; $display("FAIL gap_w0 got n=%0d %h:%h exp 3 00:001001e3", wr_addr.size(), wr_addr[1], wr_data[1]); end
    checks++; if (wr_addr[2] !== 8'd1 || wr_data[2] !== 32'h00000013) begin fails++; $display("FAIL gap_w1 got=%h:%h exp=01:00000013", wr_addr[2], wr_data[2]); end
    checks++; if (load_done !== 1'b1 || cpu_rst !== 1'b0) begin fails++; $display("FAIL gap_done got done=%b rst=%b exp 1 0", load_done, cpu_rst); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_en = 1'b1;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'hE3); send_byte(8'h01); send_byte(8'h10);
    byte_in = 8'h00; byte_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (byte_ready !== 1'b0 || cpu_rst !== 1'b1 || word_count !== 16'd0) begin fails++; $display("FAIL rstmid_immediate got rdy=%b rst=%b wc=%0d exp 0 1 0", byte_ready, cpu_rst, word_count); end
    load_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr_addr.size() != 0) begin fails++; $display("FAIL rstmid_nowrite got=%0d exp=0", wr_addr.size()); end
    checks++; if (load_done !== 1'b0 || load_err !== 1'b0 || cpu_rst !== 1'b1) begin fails++; $display("FAIL rstmid_status got done=%b err=%b rst=%b exp 0 0 1", load_done, load_err, cpu_rst); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_overflow();
    test_zero_len();
    test_gaps();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
